// File: rtl/adc_if_pkg.sv
// Shared definitions for the ADC data-out interface (writer and reader sides).
package adc_if_pkg;

    localparam int DATA_W_DEFAULT = 24;
    localparam int N_CH           = 2;
    localparam int FRAME_BITS     = N_CH * DATA_W_DEFAULT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    // Bit periods in one frame for a given channel width.
    function automatic int frame_bits(input int data_w);
        return N_CH * data_w;
    endfunction

endpackage

// File: rtl/dout_writer_dclk_gen.sv
// Free-running serial clock divider. Ticks are combinational and mark the
// clk_i cycle whose closing edge moves dclk_o, so logic updated on a tick
// changes in step with the dclk edge.
module dclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic dclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          dclk_q, dclk_d;
    logic          wrap;

    assign wrap = (div_cnt_q == DIV_LAST);

    // Divider advance and dclk toggle on wrap.
    always_comb begin
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        dclk_d    = wrap ? ~dclk_q : dclk_q;
    end

    // Divider and dclk state.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            div_cnt_q <= '0;
            dclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            dclk_q    <= dclk_d;
        end
    end

    assign dclk_o      = dclk_q;
    assign rise_tick_o = wrap & ~dclk_q;
    assign fall_tick_o = wrap &  dclk_q;

endmodule

// File: rtl/dout_writer.sv
// ADC data-out emulator: accepts channel word pairs and serialises one
// {ch1, ch2} frame per pair, MSB first, with drdy marking the first bit.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no frame; dout/drdy low, start as soon as holding is full
// SHIFT | frame bits leaving MSB first, drdy high on bit 0 only
// GAP   | GAP_BITS idle periods after a frame before next start
module dout_writer
    import adc_if_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int GAP_BITS = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] ch1_i,
    input  logic [DATA_W-1:0] ch2_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              dclk_o,
    output logic              drdy_o,
    output logic              dout_o,
    output logic              frame_done_o,
    output logic [15:0]       frames_o
);

    localparam int FRAME_W = frame_bits(DATA_W);
    localparam int BW      = $clog2(FRAME_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
    localparam int GW      = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

    logic fall_tick;

    dclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_dclk_gen (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .dclk_o      (dclk_o),
        .rise_tick_o (),
        .fall_tick_o (fall_tick)
    );

    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_ch1_q, hold_ch1_d;
    logic [DATA_W-1:0] hold_ch2_q, hold_ch2_d;
    logic              ready_q;

    tx_state_t          state_q;
    logic [FRAME_W-1:0] shift_q;
    logic [BW-1:0]      bit_cnt_q;
    logic [GW-1:0]      gap_cnt_q;
    logic               drdy_q;
    logic               dout_q;
    logic               frame_done_q;
    logic [15:0]        frames_q;

    logic accept;
    logic gap_done;
    logic start_frame;

    assign accept      = valid_i & ready_q;
    assign gap_done    = (state_q == GAP) && (gap_cnt_q == '0);
    assign start_frame = fall_tick & hold_full_q & ((state_q == IDLE) | gap_done);

    // Holding register: a start frees it, an accept (same cycle or not) refills it.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_ch1_d  = hold_ch1_q;
        hold_ch2_d  = hold_ch2_q;
        if (start_frame) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_ch1_d  = ch1_i;
            hold_ch2_d  = ch2_i;
        end
    end

    // Holding register state; ready is the registered inverse of next fullness.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            hold_full_q <= 1'b0;
            hold_ch1_q  <= '0;
            hold_ch2_q  <= '0;
            ready_q     <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_ch1_q  <= hold_ch1_d;
            hold_ch2_q  <= hold_ch2_d;
            ready_q     <= ~hold_full_d;
        end
    end

    // Frame FSM; every state and output change is gated by the dclk fall tick.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            drdy_q       <= 1'b0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frames_q     <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (fall_tick) begin
                case (state_q)
                    IDLE, GAP: begin
                        if (start_frame) begin
                            state_q   <= SHIFT;
                            shift_q   <= {hold_ch1_q, hold_ch2_q};
                            bit_cnt_q <= '0;
                            drdy_q    <= 1'b1;
                            dout_q    <= hold_ch1_q[DATA_W-1];
                        end else if (gap_done) begin
                            state_q <= IDLE;
                        end else if (state_q == GAP) begin
                            gap_cnt_q <= gap_cnt_q - 1'b1;
                        end
                    end
                    SHIFT: begin
                        drdy_q <= 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q      <= GAP;
                            gap_cnt_q    <= GAP_LAST;
                            dout_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            frames_q     <= frames_q + 16'd1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= {shift_q[FRAME_W-2:0], 1'b0};
                            dout_q    <= shift_q[FRAME_W-2];
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ready_o      = ready_q;
    assign drdy_o       = drdy_q;
    assign dout_o       = dout_q;
    assign frame_done_o = frame_done_q;
    assign frames_o     = frames_q;

endmodule

// File: tb/tb_dout_writer.sv
// Bench for dout_writer: a reader model reassembles frames at dclk rising
// edges and compares them against pairs queued when they were offered.
module tb_dout_writer;

    localparam int CLK_DIV   = 2;
    localparam int DATA_W    = 24;
    localparam int GAP_BITS  = 2;
    localparam int FW        = 2 * DATA_W;
    localparam int FRAME_CYC = (FW + GAP_BITS) * 2 * CLK_DIV;

    logic              clk = 1'b0;
    logic              reset_i = 1'b0;
    logic [DATA_W-1:0] ch1 = '0;
    logic [DATA_W-1:0] ch2 = '0;
    logic              valid = 1'b0;
    logic              ready_o, dclk_o, drdy_o, dout_o, frame_done_o;
    logic [15:0]       frames_o;

    int errors = 0;
    int checks = 0;

    logic [FW-1:0] sb[$];

    // reader model state
    int          cyc = 0;
    int          mon_nb = 0;
    int          captured = 0;
    int          starts = 0;
    int          done_cnt = 0;
    int          drdy_run = 0;
    int          start_last = 0;
    int          start_prev = 0;
    bit          collecting = 0;
    bit          prev_dclk = 0;
    bit          prev_drdy = 0;
    logic [FW-1:0] shreg = '0;
    logic [FW-1:0] exp_w;

    dout_writer #(
        .CLK_DIV  (CLK_DIV),
        .DATA_W   (DATA_W),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .ch1_i        (ch1),
        .ch2_i        (ch2),
        .valid_i      (valid),
        .ready_o      (ready_o),
        .dclk_o       (dclk_o),
        .drdy_o       (drdy_o),
        .dout_o       (dout_o),
        .frame_done_o (frame_done_o),
        .frames_o     (frames_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reader model: sample mid-cycle, capture bits on dclk rising edges.
    always @(negedge clk) begin
        if (!reset_i) begin
            collecting = 0;
            mon_nb     = 0;
            prev_dclk  = 0;
            prev_drdy  = 0;
            drdy_run   = 0;
        end else begin
            if (drdy_o === 1'b1) begin
                drdy_run++;
            end else if (drdy_run != 0) begin
                checks++;
                if (drdy_run != 2 * CLK_DIV) begin
                    errors++;
                    $display("FAIL drdy_width got=%0d cycles want=%0d", drdy_run, 2 * CLK_DIV);
                end
                drdy_run = 0;
            end
            if (drdy_o === 1'b1 && !prev_drdy) begin
                starts++;
                start_prev = start_last;
                start_last = cyc;
            end
            if (frame_done_o === 1'b1) done_cnt++;
            if (dclk_o === 1'b1 && !prev_dclk) begin
                if (drdy_o === 1'b1) begin
                    if (collecting) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_truncated got=%0d bits want=%0d", mon_nb, FW);
                    end
                    collecting = 1;
                    mon_nb     = 1;
                    shreg      = {{(FW-1){1'b0}}, dout_o};
                end else if (collecting) begin
                    shreg = {shreg[FW-2:0], dout_o};
                    mon_nb++;
                end
                if (collecting && mon_nb == FW) begin
                    collecting = 0;
                    captured++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected got=%h want=none", shreg);
                    end else begin
                        exp_w = sb.pop_front();
                        if (shreg !== exp_w) begin
                            errors++;
                            $display("FAIL frame_data got=%h want=%h", shreg, exp_w);
                        end
                    end
                end
            end
            prev_dclk = dclk_o;
            prev_drdy = drdy_o;
        end
    end

    task automatic send_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             output int stall);
        @(negedge clk);
        ch1   = a;
        ch2   = b;
        valid = 1'b1;
        stall = 0;
        while (ready_o !== 1'b1 && stall < 2000) begin
            @(negedge clk);
            stall++;
        end
        if (stall >= 2000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=ready_low want=ready_high");
        end else begin
            sb.push_back({a, b});
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_captured(input int n, input int budget);
        int k = 0;
        while (captured < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (captured < n) begin
            errors++;
            $display("FAIL capture_timeout got=%0d want=%0d", captured, n);
        end
    endtask

    task automatic test_reset();
        int  c;
        bit  pd;
        int  bad;
        repeat (3) @(negedge clk);
        checks++; if (dclk_o !== 1'b0) begin errors++; $display("FAIL rst_dclk got=%b want=0", dclk_o); end
        checks++; if (drdy_o !== 1'b0) begin errors++; $display("FAIL rst_drdy got=%b want=0", drdy_o); end
        checks++; if (dout_o !== 1'b0) begin errors++; $display("FAIL rst_dout got=%b want=0", dout_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", ready_o); end
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", frame_done_o); end
        checks++; if (frames_o !== 16'd0) begin errors++; $display("FAIL rst_frames got=%0d want=0", frames_o); end
        reset_i = 1'b1;
        c = 0;
        while (c < 20) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 1) begin
                checks++;
                if (ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_release got=%b want=1", ready_o);
                end
            end
            if (dclk_o === 1'b1) break;
        end
        checks++;
        if (c != CLK_DIV) begin
            errors++;
            $display("FAIL first_rise got=%0d cycles want=%0d", c, CLK_DIV);
        end
        c   = 0;
        pd  = 1'b1;
        bad = 0;
        while (c < 40) begin
            @(posedge clk);
            #1;
            c++;
            if (drdy_o !== 1'b0 || dout_o !== 1'b0) bad++;
            if (dclk_o === 1'b1 && !pd) break;
            pd = dclk_o;
        end
        checks++;
        if (c != 2 * CLK_DIV) begin
            errors++;
            $display("FAIL dclk_period got=%0d want=%0d", c, 2 * CLK_DIV);
        end
        repeat (20) begin
            @(negedge clk);
            if (drdy_o !== 1'b0 || dout_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_lines got=%0d nonzero samples want=0", bad);
        end
    endtask

    task automatic test_single();
        int st;
        int d0 = done_cnt;
        int n0 = captured;
        send_pair(24'h800001, 24'h7FFFFE, st);
        wait_captured(n0 + 1, FRAME_CYC * 3);
        repeat (3 * CLK_DIV) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL single_done got=%0d want=%0d", done_cnt - d0, 1);
        end
        checks++;
        if (frames_o !== 16'd1) begin
            errors++;
            $display("FAIL single_frames got=%0d want=1", frames_o);
        end
    endtask

    task automatic test_back_to_back();
        int sa, sb_st, sc;
        int s0 = starts;
        int n0 = captured;
        send_pair(24'h123456, 24'hABCDEF, sa);
        send_pair(24'h000000, 24'hFFFFFF, sb_st);
        checks++;
        if (starts != s0 + 1) begin
            errors++;
            $display("FAIL b2b_second_accept got=%0d starts want=%0d", starts - s0, 1);
        end
        send_pair(24'h5A5A5A, 24'hA5A5A5, sc);
        checks++;
        if (sc < FW) begin
            errors++;
            $display("FAIL b2b_third_stall got=%0d cycles want>=%0d", sc, FW);
        end
        checks++;
        if (starts != s0 + 2) begin
            errors++;
            $display("FAIL b2b_third_accept got=%0d starts want=%0d", starts - s0, 2);
        end
        checks++;
        if (start_last - start_prev != FRAME_CYC) begin
            errors++;
            $display("FAIL b2b_gap_ab got=%0d want=%0d", start_last - start_prev, FRAME_CYC);
        end
        wait_captured(n0 + 3, FRAME_CYC * 5);
        checks++;
        if (start_last - start_prev != FRAME_CYC) begin
            errors++;
            $display("FAIL b2b_gap_bc got=%0d want=%0d", start_last - start_prev, FRAME_CYC);
        end
    endtask

    task automatic test_loopback();
        int st;
        int n0 = captured;
        for (int i = 0; i < 100; i++) begin
            send_pair(DATA_W'($urandom), DATA_W'($urandom), st);
        end
        wait_captured(n0 + 100, FRAME_CYC * 4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL loopback_left got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_reset_midframe();
        int st, k, s0, n0;
        send_pair(24'hC0FFEE, 24'h135790, st);
        k = 0;
        while (!(collecting && mon_nb >= 17) && k < FRAME_CYC * 2) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!(collecting && mon_nb >= 17)) begin
            errors++;
            $display("FAIL midframe_reach got=%0d bits want=17", mon_nb);
        end
        #2;
        reset_i = 1'b0;
        #1;
        checks++;
        if ({dclk_o, drdy_o, dout_o, ready_o, frame_done_o} !== 5'b0 || frames_o !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got=%b%b%b%b%b/%0d want=00000/0",
                     dclk_o, drdy_o, dout_o, ready_o, frame_done_o, frames_o);
        end
        @(negedge clk);
        sb.delete();
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        s0 = starts;
        n0 = captured;
        repeat (FRAME_CYC + 50) @(negedge clk);
        checks++;
        if (starts != s0 || captured != n0) begin
            errors++;
            $display("FAIL residual_frame got=%0d starts want=0", starts - s0);
        end
        checks++;
        if (frames_o !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_frames got=%0d want=0", frames_o);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got=%b want=1", ready_o);
        end
    endtask

    task automatic test_wrap();
        int st;
        int d0, n0;
        @(negedge clk);
        force dut.frames_q = 16'hFFFF;
        @(negedge clk);
        release dut.frames_q;
        @(negedge clk);
        checks++;
        if (frames_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload got=%0d want=65535", frames_o);
        end
        d0 = done_cnt;
        n0 = captured;
        send_pair(24'h7FFFFF, 24'h800000, st);
        wait_captured(n0 + 1, FRAME_CYC * 3);
        repeat (3 * CLK_DIV) @(negedge clk);
        checks++;
        if (frames_o !== 16'd0) begin
            errors++;
            $display("FAIL wrap_frames got=%0d want=0", frames_o);
        end
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL wrap_done got=%0d want=1", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_loopback();
        test_reset_midframe();
        test_wrap();
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dout_writer.md
Name: dout_writer

Overview:
- Serial transmitter that emulates the ADC data-out interface: dclk, drdy and dout carrying two 24-bit signed channels per frame.
- Two uses: loopback source for DoutReader (pmoda → pmodb cable) and a simulation stimulus model.
- Takes channel words over a valid/ready handshake and serialises one frame per accepted word pair.
- Sits beside DoutReader in the main design and the ADC test benches.

Parameters:
- CLK_DIV, 4, clk_i cycles per dclk half-period; legal values ≥1.
- DATA_W, 24, bits per channel.
- GAP_BITS, 2, minimum idle dclk periods between frames; legal values ≥1.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-low reset.
- ch1_i  in  DATA_W  channel 1 word, signed.
- ch2_i  in  DATA_W  channel 2 word, signed.
- valid_i  in  1  channel words valid.
- ready_o  out  1  holding register empty; a word pair is accepted when valid_i && ready_o.
- dclk_o  out  1  serial clock; free-running.
- drdy_o  out  1  frame marker.
- dout_o  out  1  serial data, MSB first.
- frame_done_o  out  1  one-cycle pulse after the last bit period of a frame.
- frames_o  out  16  count of completed frames; wraps at 65535 → 0.

Behaviour:
- Reset (reset_i=0, async): dclk_o=0, drdy_o=0, dout_o=0, ready_o=0, frame_done_o=0, frames_o=0. Holding and shift registers are cleared. A frame in flight is abandoned with no partial completion. ready_o rises on the first clk_i edge after reset release.
- dclk generation:
  - Divider counts 0..CLK_DIV-1. dclk_o toggles when the count wraps, so the period is 2*CLK_DIV clk_i cycles.
  - The first rising edge comes CLK_DIV cycles after reset release.
  - fall_tick marks the clk cycle in which dclk_o goes 1→0.
  - All changes to drdy_o, dout_o and the state happen only on fall_tick. The receiver samples on the dclk rising edge, giving half a period of setup and hold.
- Holding register (1 deep):
  - Loaded on valid_i && ready_o; ready_o then deasserts in the next cycle.
  - Freed when its contents move to the shift register at frame start. The next pair can therefore be accepted while a frame is shifting.
  - When a frame starts in the same cycle as a new accept: the transfer uses the old contents and the new pair is written to the holding register.
  - valid_i while ready_o=0 is not accepted. The source holds its data.
- Frame layout: 2*DATA_W bit periods. {ch1, ch2} is sent MSB first. drdy_o=1 during exactly the first bit period (ch1 MSB) and 0 for the rest.
- FSM:
  - IDLE: dout_o=0, drdy_o=0. On fall_tick with holding full → SHIFT: load shift register, drdy_o=1, dout_o=ch1[DATA_W-1], bit counter=0. On fall_tick with holding empty → stay in IDLE (underrun; dclk keeps running).
  - SHIFT: on each fall_tick, bit counter +1, shift left, drdy_o=0. After bit 2*DATA_W-1 completes (next fall_tick) → GAP: frame_done_o pulses for that cycle, frames_o increments, dout_o=0.
  - GAP: wait GAP_BITS fall_ticks with dout_o=0, then → IDLE. The frame-start check happens on that same fall_tick, so back-to-back frames are separated by exactly GAP_BITS periods.
- No sign manipulation: bit patterns are sent verbatim.
- Frame period at full rate is (2*DATA_W+GAP_BITS)*2*CLK_DIV clk_i cycles.

Decomposition:
- Package adc_if_pkg:
  - DATA_W_DEFAULT=24, N_CH=2, FRAME_BITS=N_CH*DATA_W.
  - Enum tx_state_t {IDLE, SHIFT, GAP}.
  - Shared with DoutReader.
- Sub-module dclk_gen (parameter CLK_DIV):
  - Outputs dclk_o, rise_tick_o, fall_tick_o.
  - Reusable by a future reader-side bench model.

Test Plan:
- Reset release with CLK_DIV=2 and no valid_i → dclk_o period is 4 clk; drdy_o and dout_o stay 0; ready_o=1 one cycle after release.
- Single pair ch1=0x800001, ch2=0x7FFFFE → one frame: drdy_o high for the first period only. Bits captured at dclk rising edges reassemble to 0x800001 / 0x7FFFFE. frame_done_o pulses once and frames_o=1.
- Back-to-back pairs (0x123456/0xABCDEF, then 0x000000/0xFFFFFF), with the second presented during the first frame → exactly GAP_BITS=2 idle periods between frames; both frames are bit-exact. The third valid_i is stalled (ready_o=0) until the second frame starts.
- Loopback: dclk_o/drdy_o/dout_o feed DoutReader with 100 random pairs → DoutReader ch1_o/ch2_o match every sent pair in order.
- reset_i pulled low at bit 17 of a frame → all outputs 0 within the same cycle (async); after release, no residual frame and frames_o=0.
- Preload frames_o to 65535 via 65535 frames (or force), then send one more frame → frames_o wraps to 0; frame_done_o still pulses.
